// File: rtl/frame_gate.sv
// Channel-burst gate: discards beats until N_CH-beat bursts lock, then forwards them tagged with tuser/tlast.
// Optional statistics ports/counters are enabled by defining FRAME_GATE_STATUS_EN.
module frame_gate #(
  parameter int DATA_W    = 96,
  parameter int N_CH      = 16,
  parameter int FRAME_LEN = 256,
  parameter int CH_W      = $clog2(N_CH),
  parameter int CNT_W     = $clog2(FRAME_LEN) + 1
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_aresetn,
  input  logic              enable,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [CH_W-1:0]   m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              gate_open
`ifdef FRAME_GATE_STATUS_EN
  ,
  input  logic              clear_stats,
  output logic [31:0]       drop_count,
  output logic [15:0]       lock_loss_count
`endif
);

  typedef enum logic {SEEK, OPEN} state_e;

  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(FRAME_LEN - N_CH - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  run_q, run_d;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              open_q;
  logic              beat;
  logic              idle;
  logic              lock_loss;

  assign s_axis_tready = (state_q == SEEK) | m_axis_tready;
  assign m_axis_tvalid = (state_q == OPEN) & s_axis_tvalid;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tuser  = ch_q;
  assign m_axis_tlast  = (ch_q == CH_LAST);
  assign gate_open     = open_q;

  assign beat = s_axis_tvalid & s_axis_tready;
  assign idle = ~s_axis_tvalid;

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    idle_d    = idle_q;
    ch_d      = ch_q;
    lock_loss = 1'b0;
    case (state_q)
      SEEK: begin
        if (!enable) begin
          run_d = '0;
        end else if (beat) begin
          if (run_q == RUN_LAST) begin
            state_d = OPEN;
            run_d   = '0;
            idle_d  = '0;
            ch_d    = '0;
          end else if (run_q != '1) begin
            run_d = run_q + 1'b1;
          end
        end else if (idle) begin
          run_d = '0;
        end
      end
      OPEN: begin
        if (!enable) begin
          state_d = SEEK;
        end else if (beat) begin
          ch_d   = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
          idle_d = '0;
        end else if (idle) begin
          // A gap mid-burst is a truncated frame; a gap between frames only fails once it exceeds the period.
          if (ch_q != '0 || idle_q == IDLE_LAST) begin
            state_d   = SEEK;
            lock_loss = 1'b1;
          end else if (idle_q != '1) begin
            idle_d = idle_q + 1'b1;
          end
        end
        if (state_d == SEEK) begin
          run_d  = '0;
          idle_d = '0;
          ch_d   = '0;
        end
      end
      default: state_d = SEEK;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q <= SEEK;
      run_q   <= '0;
      idle_q  <= '0;
      ch_q    <= '0;
      open_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      idle_q  <= idle_d;
      ch_q    <= ch_d;
      open_q  <= (state_d == OPEN);
    end
  end

`ifdef FRAME_GATE_STATUS_EN
  logic [31:0] drop_q;
  logic [15:0] loss_q;

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      drop_q <= '0;
      loss_q <= '0;
    end else if (clear_stats) begin
      drop_q <= '0;
      loss_q <= '0;
    end else begin
      if (state_q == SEEK && beat && drop_q != '1) drop_q <= drop_q + 1'b1;
      if (lock_loss && loss_q != '1)               loss_q <= loss_q + 1'b1;
    end
  end

  assign drop_count      = drop_q;
  assign lock_loss_count = loss_q;
`endif

endmodule

// File: tb/tb_frame_gate.sv
// Bench for frame_gate (N_CH=4, FRAME_LEN=16): table vectors, directed corner sequences and random traffic
// against a cycle-level reference model; statistics are checked when FRAME_GATE_STATUS_EN is defined.
module tb_frame_gate;
  localparam int DW  = 16;
  localparam int NCH = 4;
  localparam int FL  = 16;
  localparam int TH  = FL - NCH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [1:0]    m_tuser;
  logic          m_tlast;
  logic          gate_open;
  logic          clr = 1'b0;
`ifdef FRAME_GATE_STATUS_EN
  logic [31:0]   drop_count;
  logic [15:0]   lock_loss_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit mlk;
  int mpos, mgap, mstk, mdrop, mloss;

  always #5 clk = ~clk;

  frame_gate #(.DATA_W(DW), .N_CH(NCH), .FRAME_LEN(FL)) dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .enable         (en),
    .s_axis_tdata   (s_tdata),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .m_axis_tuser   (m_tuser),
    .m_axis_tlast   (m_tlast),
    .gate_open      (gate_open)
`ifdef FRAME_GATE_STATUS_EN
    ,
    .clear_stats    (clr),
    .drop_count     (drop_count),
    .lock_loss_count(lock_loss_count)
`endif
  );

  typedef struct {
    logic       v, mr, e;
    logic       tr, mv;
    logic [1:0] tu;
    logic       tl, op;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mlk = 0; mpos = 0; mgap = 0; mstk = 0; mdrop = 0; mloss = 0;
  endtask

  task automatic unlock(input bit counted);
    mlk = 0; mpos = 0; mgap = 0; mstk = 0;
    if (counted) mloss++;
  endtask

  task automatic model_cmp(input string tag);
    chk({tag, ".s_tready"}, s_tready, mlk ? m_tready : 1'b1);
    chk({tag, ".m_tvalid"}, m_tvalid, mlk & s_tvalid);
    chk({tag, ".tuser"},    m_tuser,  mlk ? mpos : 0);
    chk({tag, ".tlast"},    m_tlast,  mlk && mpos == NCH - 1);
    chk({tag, ".gate_open"}, gate_open, mlk);
    chk({tag, ".tdata"},    m_tdata,  s_tdata);
`ifdef FRAME_GATE_STATUS_EN
    chk({tag, ".drop_count"}, drop_count, mdrop);
    chk({tag, ".lock_loss"},  lock_loss_count, mloss);
`endif
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
  task automatic drive(input logic v, input logic mr, input logic e, input logic c);
    s_tvalid = v; m_tready = mr; en = e; clr = c;
    s_tdata  = DW'($urandom);
    #4;
  endtask

  task automatic advance();
    bit beat, v, e, c;
    v = s_tvalid; e = en; c = clr;
    beat = v && (mlk ? m_tready : 1'b1);
    @(posedge clk);
    #1;
    if (!mlk && beat) mdrop++;
    if (!e) unlock(0);
    else if (!mlk) begin
      if (beat) begin
        mstk++;
        if (mstk == NCH) begin mlk = 1; mstk = 0; mpos = 0; mgap = 0; end
      end else if (!v) mstk = 0;
    end else begin
      if (beat) begin
        mpos = (mpos + 1) % NCH; mgap = 0;
      end else if (!v) begin
        if (mpos != 0) unlock(1);
        else begin
          mgap++;
          if (mgap == TH) unlock(1);
        end
      end
    end
    if (c) begin mdrop = 0; mloss = 0; end
  endtask

  task automatic step(input logic v, input logic mr, input logic e, input string tag);
    drive(v, mr, e, 1'b0);
    model_cmp(tag);
    advance();
  endtask

  task automatic burst(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1, 1, 1, tag);
  endtask

  initial begin
    // v mr e | s_tready m_tvalid tuser tlast gate_open
    tbl[0]  = '{1,1,1, 1,0,0,0,0};
    tbl[1]  = '{1,1,1, 1,0,0,0,0};
    tbl[2]  = '{1,1,1, 1,0,0,0,0};
    tbl[3]  = '{1,1,1, 1,0,0,0,0};
    tbl[4]  = '{1,1,1, 1,1,0,0,1};
    tbl[5]  = '{1,0,1, 0,1,1,0,1};
    tbl[6]  = '{1,0,1, 0,1,1,0,1};
    tbl[7]  = '{1,1,1, 1,1,1,0,1};
    tbl[8]  = '{1,1,1, 1,1,2,0,1};
    tbl[9]  = '{1,1,1, 1,1,3,1,1};
    tbl[10] = '{0,1,1, 1,0,0,0,1};
    tbl[11] = '{1,1,1, 1,1,0,0,1};
    tbl[12] = '{1,1,0, 1,1,1,0,1};
    tbl[13] = '{1,1,1, 1,0,0,0,0};
    tbl[14] = '{0,1,1, 1,0,0,0,0};
    tbl[15] = '{1,0,1, 1,0,0,0,0};

    model_reset();
    @(posedge clk); #1;
    s_tvalid = 1; m_tready = 0; en = 1;
    #2;
    chk("rst.s_tready", s_tready, 1);
    chk("rst.m_tvalid", m_tvalid, 0);
    chk("rst.gate_open", gate_open, 0);
    chk("rst.tuser", m_tuser, 0);
    chk("rst.tlast", m_tlast, 0);
    @(posedge clk); #1;
    rst_n = 1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].mr, tbl[i].e, 1'b0);
      chk($sformatf("tbl%0d.s_tready", i), s_tready, tbl[i].tr);
      chk($sformatf("tbl%0d.m_tvalid", i), m_tvalid, tbl[i].mv);
      chk($sformatf("tbl%0d.tuser", i),    m_tuser,  tbl[i].tu);
      chk($sformatf("tbl%0d.tlast", i),    m_tlast,  tbl[i].tl);
      chk($sformatf("tbl%0d.gate_open", i), gate_open, tbl[i].op);
      model_cmp($sformatf("tbl%0d", i));
      advance();
    end

    // Idle-gap threshold: 11 idles keep lock, 12 drop it
    step(0, 1, 1, "g.pre");
    burst(NCH, "g.lock");
    chk("gap.locked", gate_open, 1);
    for (int i = 0; i < TH - 1; i++) step(0, 1, 1, "g.idle11");
    chk("gap11.open", gate_open, 1);
    burst(NCH, "g.frame");
    for (int i = 0; i < TH; i++) step(0, 1, 1, "g.idle12");
    chk("gap12.closed", gate_open, 0);

    // Truncated burst loses lock; the following burst is dropped
    burst(NCH, "t.lock");
    burst(NCH, "t.frame");
    burst(2, "t.trunc");
    chk("trunc.open_before_idle", gate_open, 1);
    step(0, 1, 1, "t.idle");
    chk("trunc.closed", gate_open, 0);
    burst(NCH, "t.redrop");
    chk("trunc.relocked", gate_open, 1);

    // Downstream stall holds channel index
    burst(1, "s.ch0");
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, "s.stall");
      chk("stall.tuser", m_tuser, 1);
    end
    burst(3, "s.rest");
    chk("stall.wrapped", m_tuser, 0);

    // Asynchronous reset mid-burst, then relock and clear_stats
    burst(2, "r.mid");
    drive(1, 1, 1, 1'b0);
    #2 rst_n = 0;
    #1;
    chk("arst.gate_open", gate_open, 0);
    chk("arst.m_tvalid", m_tvalid, 0);
    chk("arst.s_tready", s_tready, 1);
    chk("arst.tuser", m_tuser, 0);
    chk("arst.tlast", m_tlast, 0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    burst(NCH - 1, "r.partial");
    chk("relock.not_yet", gate_open, 0);
    burst(1, "r.fourth");
    chk("relock.open", gate_open, 1);
    step(1, 1, 0, "r.disable");
    drive(1, 1, 1, 1'b1);
    model_cmp("r.clear");
    advance();
`ifdef FRAME_GATE_STATUS_EN
    chk("clear.drop_count", drop_count, 0);
`endif

    // Random traffic with occasional long gaps and enable drops
    begin
      int idle_left = 0;
      logic v, mr, e;
      for (int n = 0; n < 3000; n++) begin
        if (idle_left == 0 && $urandom_range(0, 39) == 0) idle_left = $urandom_range(8, 14);
        if (idle_left > 0) begin v = 0; idle_left--; end
        else v = ($urandom_range(0, 9) < 8);
        mr = ($urandom_range(0, 3) != 0);
        e  = ($urandom_range(0, 59) != 0);
        drive(v, mr, e, ($urandom_range(0, 199) == 0));
        model_cmp("rnd");
        advance();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
